cpu_instruction_encoder: RTL

- Inverse of the instruction field splitter: packs RV32I fields (opcode, funct3, funct7, rs1, rs2, rd, immediate) into a 32-bit instruction word according to a selected format.
- Used by the boot/program loader and by test infrastructure to stream encoded words into instruction memory.
- Input and output both use a valid/ready handshake, with a 2-entry output buffer between them.
- Each output word carries an auto-incrementing byte address; malformed requests are dropped and reported through a sticky error flag.

---
 rtl/cpu_instruction_encoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_instruction_encoder.sv
// Purpose: packs RV32I instruction fields into a 32-bit word for the selected
// format and streams the words out through a 2-entry FIFO. Each output word
// carries a byte address that wraps at IMEM_WORDS. Malformed requests are
// consumed without producing a word, and they set a sticky error flag.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_clear               synchronous flush of buffer, address, count and error
//   i_valid / o_ready     request handshake (format + fields + immediate)
//   o_valid / i_ready     output handshake for the buffer head word
//   o_instruction, o_addr head word and its byte address
//   o_count               number of words popped since reset/clear
//   o_error               sticky drop indicator
module cpu_instruction_encoder #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_format,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [4:0]        i_rd,
  input  logic [31:0]       i_imm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instruction,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_error
);

  localparam int unsigned INSN_W = 32;
  localparam int unsigned OCC_W  = 2;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(IMEM_WORDS * 4 - 1);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [INSN_W-1:0] enc_word;
  logic              enc_drop;
  logic              fits_12;
  logic              fits_13;
  logic              fits_21;

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [INSN_W-1:0] tail_q, tail_d;
  logic [INSN_W-1:0] head_d;
  logic [ADDR_W-1:0] addr_d, count_d;
  logic              error_d;
  logic              accept, pop, push;

  // Signed range checks: the immediate fits in N bits when all bits above N-1 match bit N-1.
  assign fits_12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign fits_13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign fits_21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  // Field packing and legality check for the presented request.
  always_comb begin
    enc_word = '0;
    enc_drop = 1'b0;
    case (i_format)
      FMT_R: enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        enc_drop = ~fits_12;
      end
      FMT_S: begin
        enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        enc_drop = ~fits_12;
      end
      FMT_B: begin
        enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
        // 13-bit range [-4096, 4095] plus even gives [-4096, 4094].
        enc_drop = i_imm[0] | ~fits_13;
      end
      FMT_U: enc_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: begin
        enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        enc_drop = i_imm[0] | ~fits_21;
      end
      default: enc_drop = 1'b1;
    endcase
  end

  assign accept = i_valid & o_ready;
  assign pop    = o_valid & i_ready;
  assign push   = accept & ~enc_drop;

  // Next-state for the FIFO, address/count and error flag; clear wins over everything.
  always_comb begin
    occ_d   = occ_q;
    head_d  = o_instruction;
    tail_d  = tail_q;
    addr_d  = o_addr;
    count_d = o_count;
    error_d = o_error;
    if (i_clear) begin
      occ_d   = '0;
      addr_d  = '0;
      count_d = '0;
      error_d = 1'b0;
    end else begin
      if (accept & enc_drop) begin
        error_d = 1'b1;
      end
      if (pop) begin
        addr_d  = (o_addr + ADDR_STEP) & ADDR_MASK;
        count_d = o_count + ADDR_W'(1);
      end
      case (occ_q)
        OCC_W'(0): begin
          if (push) begin
            head_d = enc_word;
            occ_d  = OCC_W'(1);
          end
        end
        OCC_W'(1): begin
          if (push && pop) begin
            head_d = enc_word;
          end else if (push) begin
            tail_d = enc_word;
            occ_d  = OCC_W'(2);
          end else if (pop) begin
            occ_d = OCC_W'(0);
          end
        end
        default: begin
          // Full: o_ready is low, so only a pop can happen here.
          if (pop) begin
            head_d = tail_q;
            occ_d  = OCC_W'(1);
          end
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q         <= '0;
      tail_q        <= '0;
      o_instruction <= '0;
      o_valid       <= 1'b0;
      o_ready       <= 1'b1;
      o_addr        <= '0;
      o_count       <= '0;
      o_error       <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      tail_q        <= tail_d;
      o_instruction <= head_d;
      o_valid       <= (occ_d != OCC_W'(0));
      o_ready       <= (occ_d < OCC_W'(2));
      o_addr        <= addr_d;
      o_count       <= count_d;
      o_error       <= error_d;
    end
  end

endmodule
